parity_generator_4b: RTL and testbench

Registered parity generator. It computes the parity bit of a DATA_W-bit word (default 4) and emits it prepended to the word as a DATA_W+1-bit codeword. It sits on the transmit side of a data path, ahead of a link or storage element that carries the parity bit. An optional checker can be compiled in for loopback/receive-side verification.

---
 rtl/parity_pkg.sv | 16 +
 rtl/parity_tree.sv | 12 +
 rtl/parity_generator_4b.sv | 77 +++++++
 tb/tb_parity_generator_4b.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity generator slice.
package parity_pkg;

  localparam int unsigned DEFAULT_DATA_W = 4;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  // Reference parity for words up to 32 bits; unused upper bits must be zero.
  function automatic logic calc_parity(input logic [31:0] word, input parity_mode_e mode);
    return (^word) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR reduction of a W-bit word with an optional odd-sense invert.
module parity_tree #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] word,
  input  logic         odd,
  output logic         par
);

  assign par = (^word) ^ odd;

endmodule

// File: rtl/parity_generator_4b.sv
// Registered parity generator: out = {parity, in}, one cycle latency.
// Define PARITY_GEN_CHECK_EN to add the receive-side parity checker.
module parity_generator_4b
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter bit          ODD_DEFAULT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  input  logic              odd_sel,
  output logic              out_valid,
  output logic              parity,
  output logic [DATA_W:0]   out
`ifdef PARITY_GEN_CHECK_EN
  ,
  input  logic              chk_valid,
  input  logic [DATA_W:0]   chk_word,
  output logic              chk_err
`endif
);

  parity_mode_e      mode;
  logic              gen_par;
  logic [DATA_W-1:0] data_q;
  logic              par_q;
  logic              vld_q;

  assign mode = parity_mode_e'(odd_sel);

  parity_tree #(.W(DATA_W)) u_gen_tree (
    .word (in),
    .odd  (mode == PAR_ODD),
    .par  (gen_par)
  );

  // Parity resets to the default sense so the held codeword stays self-consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      par_q  <= ODD_DEFAULT;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        data_q <= in;
        par_q  <= gen_par;
      end
    end
  end

  assign out       = {par_q, data_q};
  assign parity    = par_q;
  assign out_valid = vld_q;

`ifdef PARITY_GEN_CHECK_EN
  logic chk_mis;

  // Reducing the whole codeword under the current sense yields 1 exactly on mismatch.
  parity_tree #(.W(DATA_W + 1)) u_chk_tree (
    .word (chk_word),
    .odd  (mode == PAR_ODD),
    .par  (chk_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (chk_valid) begin
      chk_err <= chk_mis;
    end
  end
`endif

endmodule

// File: tb/tb_parity_generator_4b.sv
// Scoreboard bench for parity_generator_4b with directed, hand-computed vectors.
`timescale 1ns/100ps
module tb_parity_generator_4b;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in;
  logic       odd_sel;
  logic       out_valid;
  logic       parity;
  logic [4:0] out;
`ifdef PARITY_GEN_CHECK_EN
  logic       chk_valid;
  logic [4:0] chk_word;
  logic       chk_err;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [4:0]  exp_q[$];
  logic [4:0]  mon_e;

  parity_generator_4b #(.DATA_W(4), .ODD_DEFAULT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in),
    .odd_sel   (odd_sel),
    .out_valid (out_valid),
    .parity    (parity),
    .out       (out)
`ifdef PARITY_GEN_CHECK_EN
    ,
    .chk_valid (chk_valid),
    .chk_word  (chk_word),
    .chk_err   (chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented codeword must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: actual=%b required=no_output at %0t", out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out", 32'(out), 32'(mon_e));
        chk("parity", 32'(parity), 32'(mon_e[4]));
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic odd, input logic [4:0] e);
    in_valid = 1'b1;
    in       = d;
    odd_sel  = odd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n, input logic [4:0] hold);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("hold_out", 32'(out), 32'(hold));
      chk("hold_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in       = '0;
    odd_sel  = 1'b0;
`ifdef PARITY_GEN_CHECK_EN
    chk_valid = 1'b0;
    chk_word  = '0;
`endif
    #3;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_parity", 32'(parity), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // even mode, isolated words
    send(4'b0011, 1'b0, 5'b00011);
    idle(1, 5'b00011);
    send(4'b1011, 1'b0, 5'b11011);
    idle(3, 5'b11011);
    send(4'b0000, 1'b0, 5'b00000);
    idle(1, 5'b00000);
    send(4'b0111, 1'b0, 5'b10111);
    idle(1, 5'b10111);
    send(4'b1111, 1'b0, 5'b01111);
    idle(1, 5'b01111);

    // odd mode
    send(4'b0000, 1'b1, 5'b10000);
    idle(1, 5'b10000);
    send(4'b1011, 1'b1, 5'b01011);
    idle(1, 5'b01011);

    // back-to-back
    send(4'b0001, 1'b0, 5'b10001);
    send(4'b0011, 1'b0, 5'b00011);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    send(4'b0111, 1'b0, 5'b10111);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    idle(1, 5'b10111);

    // mid-stream async reset with a word in flight (never expected)
    send(4'b0101, 1'b0, 5'b00101);
    in_valid = 1'b1;
    in       = 4'b0110;
    #6;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out), 32'd0);
    chk("async_rst_parity", 32'(parity), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'b1000, 1'b0, 5'b11000);
    idle(2, 5'b11000);

`ifdef PARITY_GEN_CHECK_EN
    odd_sel   = 1'b0;
    chk_valid = 1'b1;
    chk_word  = 5'b11011;
    @(posedge clk);
    #1;
    chk("chk_err_good", 32'(chk_err), 32'd0);
    chk_word = 5'b01011;
    @(posedge clk);
    #1;
    chk("chk_err_bad", 32'(chk_err), 32'd1);
    chk_valid = 1'b0;
    chk_word  = 5'b11011;
    @(posedge clk);
    #1;
    chk("chk_err_hold", 32'(chk_err), 32'd1);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
